// File: rtl/pmips_pkg.sv
// Shared definitions for the 16-bit pipelined core: the bubble instruction,
// the instruction field positions, and the fetch-stage state encoding.
package pmips_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int RS_MSB     = 12;
  localparam int RS_LSB     = 10;
  localparam int RT_MSB     = 9;
  localparam int RT_LSB     = 7;
  localparam int RD_MSB     = 6;
  localparam int RD_LSB     = 4;

  // EMPTY: nothing valid on the RAM output; RUN: RAM output holds the
  // in-flight word; STALL: RUN frozen by the hazard controller.
  typedef enum logic [1:0] {
    FETCH_EMPTY = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2
  } fetch_state_t;

  function automatic logic [2:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear, used for debug event counts.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones, clear wins over increment.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction
// RAM and loads the IF/ID register, honouring stalls and branch redirects.
module fetch_stage #(
  parameter int                PC_W      = 8,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [15:0]       NOP_INSTR = pmips_pkg::NOP_INSTR
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic [15:0]     stall_count
);

  import pmips_pkg::*;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_q, inflight_d;
  logic [15:0]     instr_d;
  logic [PC_W-1:0] ifid_pc_d;
  logic            valid_d;

  // While stalled, replay the in-flight address so the RAM output stays put.
  assign imem_addr = (pc_stall && (state_q != FETCH_EMPTY)) ? inflight_q : pc_q;

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH_EMPTY;
      pc_q       <= RESET_PC;
      inflight_q <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      ifid_instr <= instr_d;
      ifid_pc    <= ifid_pc_d;
      ifid_valid <= valid_d;
    end
  end

  // Next-state logic: redirect beats stall, stall beats normal advance.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    instr_d    = ifid_instr;
    ifid_pc_d  = ifid_pc;
    valid_d    = ifid_valid;
    if (branch_taken) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = FETCH_EMPTY;
    end else begin
      case (state_q)
        FETCH_EMPTY: begin
          if (!pc_stall) begin
            inflight_d = pc_q;
            pc_d       = pc_q + PC_ONE;
            valid_d    = 1'b0;
            state_d    = FETCH_RUN;
          end
        end
        FETCH_RUN, FETCH_STALL: begin
          if (pc_stall) begin
            state_d = FETCH_STALL;
          end else begin
            instr_d    = imem_data;
            ifid_pc_d  = inflight_q;
            valid_d    = 1'b1;
            inflight_d = pc_q;
            pc_d       = pc_q + PC_ONE;
            state_d    = FETCH_RUN;
          end
        end
        default: begin
          state_d = FETCH_EMPTY;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(16)
  ) u_stall_counter (
    .clock(clock),
    .clear(reset),
    .inc  (pc_stall),
    .count(stall_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stream-level model predicts the IF/ID
// contents, RAM address and stall count for every cycle; a monitor compares.
module tb_fetch_stage;

  localparam int          PC_W     = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;
  localparam logic [15:0] NOP      = 16'h0000;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } ifidExp_t;

  logic        clock;
  logic        reset;
  logic        pc_stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic [15:0] stall_count;

  logic [15:0] mem [256];

  ifidExp_t   ifidQ [$];
  logic [7:0] addrQ [$];

  int checks = 0;
  int errors = 0;

  // Stream-level model: next PC to deliver, edges still needed before it
  // appears, and the IF/ID picture it implies.
  logic        known = 1'b0;
  logic [7:0]  expPc;
  int          fillLeft;
  logic        mValid;
  logic [15:0] mInstr;
  logic [7:0]  mPc;
  logic [15:0] mCnt;

  logic        curRst, curStall, curBr;
  logic [7:0]  curTgt;

  fetch_stage #(
    .PC_W(PC_W),
    .RESET_PC(RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc_stall(pc_stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc),
    .ifid_valid(ifid_valid),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction RAM with one cycle of read latency.
  always @(posedge clock) imem_data <= mem[imem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across the edge just taken with the inputs that were
  // applied, then apply the next inputs and predict the RAM address.
  task automatic applyStimulus(input logic rst, input logic stall, input logic br, input logic [7:0] tgt);
    ifidExp_t e;
    @(posedge clock);
    #1;
    if (curRst) begin
      known    = 1'b1;
      expPc    = RESET_PC;
      fillLeft = 2;
      mValid   = 1'b0;
      mInstr   = NOP;
      mPc      = 8'h00;
      mCnt     = 16'h0000;
    end else if (known) begin
      if (curStall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      if (curBr) begin
        expPc    = curTgt;
        fillLeft = 2;
        mValid   = 1'b0;
        mInstr   = NOP;
      end else if (!curStall) begin
        if (fillLeft > 1) begin
          fillLeft = fillLeft - 1;
          mValid   = 1'b0;
        end else begin
          fillLeft = 0;
          mValid   = 1'b1;
          mPc      = expPc;
          mInstr   = 16'hA000 + {8'h00, expPc};
          expPc    = expPc + 8'd1;
        end
      end
    end
    if (known) begin
      e.valid = mValid;
      e.instr = mInstr;
      e.pc    = mPc;
      e.cnt   = mCnt;
      ifidQ.push_back(e);
    end
    reset         = rst;
    pc_stall      = stall;
    branch_taken  = br;
    branch_target = tgt;
    curRst   = rst;
    curStall = stall;
    curBr    = br;
    curTgt   = tgt;
    if (known) begin
      addrQ.push_back((fillLeft == 2 || stall) ? expPc : expPc + 8'd1);
    end
  endtask

  // Monitor: compare whatever the model predicted for this cycle.
  always @(negedge clock) begin
    if (addrQ.size() > 0) begin
      checkOutput("imem_addr", {24'h0, imem_addr}, {24'h0, addrQ.pop_front()});
    end
    if (ifidQ.size() > 0) begin
      ifidExp_t e;
      e = ifidQ.pop_front();
      checkOutput("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
      checkOutput("ifid_instr", {16'h0, ifid_instr}, {16'h0, e.instr});
      checkOutput("ifid_pc", {24'h0, ifid_pc}, {24'h0, e.pc});
      checkOutput("stall_count", {16'h0, stall_count}, {16'h0, e.cnt});
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + i[15:0];
    reset         = 1'b1;
    pc_stall      = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    curRst        = 1'b1;
    curStall      = 1'b1;
    curBr         = 1'b0;
    curTgt        = 8'h00;

    // Reset with the hazard controller already stalling.
    applyStimulus(1, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 8'h00);
    // Three-cycle stall mid-stream.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
    // Plain redirect.
    applyStimulus(0, 0, 1, 8'h40);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00);
    // Redirect together with a stall, stall held afterwards.
    applyStimulus(0, 1, 1, 8'h40);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00);
    // Reset in the middle of a long stall.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00);
    // Wrap the PC through all-ones.
    applyStimulus(0, 0, 1, 8'hF8);
    for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] t;
      r = $urandom_range(0, 99);
      t = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
      applyStimulus(r < 2, $urandom_range(0, 99) < 30, (r >= 2) && (r < 12), t);
    end
    applyStimulus(0, 0, 0, 8'h00);

    @(negedge clock);
    @(negedge clock);
    checkOutput("queue_drain", ifidQ.size() + addrQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
